// File: rtl/s298_bist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s298_bist_ctrl_pkg
// Purpose  : Shared definitions for the s298 BIST controller: FSM state
//            encoding, LFSR tap mask, MISR polynomial and datapath widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package s298_bist_ctrl_pkg;

  localparam int PAT_W  = 3;
  localparam int RESP_W = 6;
  localparam int SIG_W  = 16;

  // x^8+x^6+x^5+x^4+1 expressed as taps on bits 7,5,4,3 of a shift-left LFSR
  localparam logic [7:0]       LFSR_TAPS = 8'hB8;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_FINISH = 3'd4
  } bist_state_e;

  // Fibonacci step: shift left, XOR of the tapped bits enters at bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/s298_bist_ctrl_misr16.sv
`default_nettype none
// ============================================================================
// Module   : bist_misr16
// Purpose  : 16-bit multiple-input signature register compacting the 6-bit
//            CUT response, with enable and synchronous clear.
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset (signature -> 0)
//            i_clr    - synchronous clear (priority over i_en)
//            i_en     - compact i_resp this cycle
//            i_resp   - CUT response word
//            o_sig    - current signature
// Revision : 1.0 - initial release
// ============================================================================
module bist_misr16
  import s298_bist_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [RESP_W-1:0] i_resp,
  output logic [SIG_W-1:0]  o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_nxt;

  always_comb begin
    w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
              ^ (r_sig[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}})
              ^ {{(SIG_W-RESP_W){1'b0}}, i_resp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_sig_nxt;
    end
  end

  assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/s298_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : s298_bist_ctrl
// Purpose  : Pseudo-random BIST controller for the s298 circuit. Clears the
//            CUT, applies N_PAT LFSR patterns, compacts the delayed responses
//            into a MISR and compares the final signature with GOLDEN_SIG.
// Ports    : CLOCK   - rising-edge clock shared with the CUT
//            RESET_N - asynchronous active-low reset
//            START   - run request, honoured in IDLE and FINISH only
//            PAT     - {G2,G1,G0} stimulus to the CUT
//            RESP    - CUT response {G133,G132,G118,G117,G67,G66}
//            BUSY    - sequence in progress (INIT/RUN/FLUSH)
//            DONE    - sequence complete, sticky until restart
//            PASS    - signature matches GOLDEN_SIG (only while DONE)
//            SIG     - current MISR contents
// Revision : 1.0 - initial release
// ============================================================================
module s298_bist_ctrl
  import s298_bist_ctrl_pkg::*;
#(
  parameter int               N_PAT      = 255,
  parameter int               INIT_CYC   = 4,
  parameter logic [7:0]       LFSR_SEED  = 8'h01,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
)
(
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              START,
  output logic [PAT_W-1:0]  PAT,
  input  logic [RESP_W-1:0] RESP,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [SIG_W-1:0]  SIG
);

  localparam logic [15:0] C_PAT_LAST  = 16'(N_PAT - 1);
  localparam logic [3:0]  C_INIT_LAST = 4'(INIT_CYC - 1);

  bist_state_e r_state;
  bist_state_e w_state_nxt;
  logic [7:0]  r_lfsr;
  logic [3:0]  r_init_cnt;
  logic [15:0] r_pat_cnt;
  logic        w_launch;
  logic        w_misr_en;

  // Next state and Moore outputs
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_misr_en   = 1'b0;
    PAT         = '0;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_INIT;
          w_launch    = 1'b1;
        end
      end
      ST_INIT: begin
        PAT  = 3'b001;
        BUSY = 1'b1;
        if (r_init_cnt == C_INIT_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        PAT  = r_lfsr[PAT_W-1:0];
        BUSY = 1'b1;
        // The response to the first pattern only arrives in the second RUN
        // cycle, so compaction lags the pattern stream by one cycle.
        w_misr_en = (r_pat_cnt != 16'd0);
        if (r_pat_cnt == C_PAT_LAST) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        BUSY        = 1'b1;
        w_misr_en   = 1'b1;
        w_state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        DONE = 1'b1;
        if (START) begin
          w_state_nxt = ST_INIT;
          w_launch    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // LFSR and counters: reloaded on every accepted START
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lfsr     <= LFSR_SEED;
      r_init_cnt <= '0;
      r_pat_cnt  <= '0;
    end else if (w_launch) begin
      r_lfsr     <= LFSR_SEED;
      r_init_cnt <= '0;
      r_pat_cnt  <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 4'd1;
    end else if (r_state == ST_RUN) begin
      r_lfsr    <= lfsr_next(r_lfsr);
      r_pat_cnt <= r_pat_cnt + 16'd1;
    end
  end

  bist_misr16 u_misr (
    .clk    (CLOCK),
    .rst_n  (RESET_N),
    .i_clr  (w_launch),
    .i_en   (w_misr_en),
    .i_resp (RESP),
    .o_sig  (SIG)
  );

  assign PASS = DONE && (SIG == GOLDEN_SIG);

endmodule
`default_nettype wire

// File: tb/tb_s298_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_s298_bist_ctrl
// Purpose  : Self-checking bench for s298_bist_ctrl. Three instances:
//            A (N_PAT=4, INIT_CYC=2, RESP=0), B (N_PAT=1, RESP=1) and
//            C (N_PAT=255) driven by a behavioural CUT stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s298_bist_ctrl;

  localparam int NC = 255;
  localparam int IC = 4;

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_lfsr(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  // CUT stand-in: response is a fixed function of the previous pattern
  function automatic logic [5:0] m_cut(input logic [2:0] p);
    return {p, p ^ 3'b101};
  endfunction

  // Signature as polynomial: multiply by x mod x^16+x^12+x^5+1, add input
  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [5:0] r);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {10'd0, r};
  endfunction

  function automatic logic [15:0] m_sig(input int n, input int flip_j, input logic [5:0] mask);
    logic [7:0]  l;
    logic [15:0] s;
    logic [5:0]  r;
    l = 8'h01;
    s = 16'h0000;
    for (int j = 1; j <= n; j++) begin
      r = m_cut(l[2:0]);
      if (j == flip_j) r = r ^ mask;
      s = m_misr(s, r);
      l = m_lfsr(l);
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD_C = m_sig(NC, 0, 6'd0);

  // ---------------- DUTs ----------------
  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        START_A, START_B, START_C;
  logic [5:0]  RESP_C;
  logic [2:0]  PAT_A, PAT_B, PAT_C;
  logic        BUSY_A, BUSY_B, BUSY_C;
  logic        DONE_A, DONE_B, DONE_C;
  logic        PASS_A, PASS_B, PASS_C;
  logic [15:0] SIG_A, SIG_B, SIG_C;

  always #5 CLOCK = ~CLOCK;

  s298_bist_ctrl #(.N_PAT(4), .INIT_CYC(2), .LFSR_SEED(8'h01), .GOLDEN_SIG(16'h0000)) dut_a (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START_A), .PAT(PAT_A), .RESP(6'h00),
    .BUSY(BUSY_A), .DONE(DONE_A), .PASS(PASS_A), .SIG(SIG_A));

  s298_bist_ctrl #(.N_PAT(1), .INIT_CYC(4), .LFSR_SEED(8'h01), .GOLDEN_SIG(16'h0001)) dut_b (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START_B), .PAT(PAT_B), .RESP(6'h01),
    .BUSY(BUSY_B), .DONE(DONE_B), .PASS(PASS_B), .SIG(SIG_B));

  s298_bist_ctrl #(.N_PAT(NC), .INIT_CYC(IC), .LFSR_SEED(8'h01), .GOLDEN_SIG(GOLD_C)) dut_c (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START_C), .PAT(PAT_C), .RESP(RESP_C),
    .BUSY(BUSY_C), .DONE(DONE_C), .PASS(PASS_C), .SIG(SIG_C));

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: event not expected (t=%0t)", nm, $time);
  endtask

  // ---------------- CUT stand-in driving instance C ----------------
  int         cyc = 0;
  int         flip_cyc = -1;
  logic [5:0] flip_mask = 6'd0;
  logic [2:0] pat_prev = 3'd0;

  always @(posedge CLOCK) cyc <= cyc + 1;
  always @(negedge CLOCK) pat_prev <= PAT_C;
  always @(posedge CLOCK) begin
    #1;
    RESP_C = m_cut(pat_prev) ^ ((cyc == flip_cyc) ? flip_mask : 6'd0);
  end

  // ---------------- scoreboard monitor for instance C ----------------
  logic [2:0]  pat_q[$];
  logic [16:0] res_q[$];
  logic        prev_done = 1'b0;

  always @(negedge CLOCK) begin
    logic [16:0] e;
    if (!RESET_N) begin
      prev_done <= 1'b0;
    end else begin
      if (BUSY_C) begin
        if (pat_q.size() == 0) fail_now("C_pat_extra");
        else chk("C_pat", {29'd0, PAT_C}, {29'd0, pat_q.pop_front()});
      end
      if (DONE_C && !prev_done) begin
        chk("C_pat_left_at_done", pat_q.size(), 0);
        if (res_q.size() == 0) fail_now("C_done_extra");
        else begin
          e = res_q.pop_front();
          chk("C_sig", {16'd0, SIG_C}, {16'd0, e[15:0]});
          chk("C_pass", {31'd0, PASS_C}, {31'd0, e[16]});
        end
      end
      prev_done <= DONE_C;
    end
  end

  // One full (or aborted) sequence on instance C
  task automatic run_c(input bit spam, input int flip_j, input logic [5:0] mask,
                       input bit chk_drop, input int abort_at);
    logic [7:0]  l;
    logic [15:0] es;
    int          s;
    @(posedge CLOCK); #1;
    START_C = 1'b1;
    s = cyc;
    for (int i = 0; i < IC; i++) pat_q.push_back(3'b001);
    l = 8'h01;
    for (int j = 1; j <= NC; j++) begin
      pat_q.push_back(l[2:0]);
      l = m_lfsr(l);
    end
    pat_q.push_back(3'b000);
    es = m_sig(NC, flip_j, mask);
    res_q.push_back({(es == GOLD_C), es});
    flip_cyc  = (flip_j > 0) ? (s + IC + flip_j + 1) : -1;
    flip_mask = mask;
    for (int k = 1; k <= IC + NC + 1; k++) begin
      @(posedge CLOCK); #1;
      START_C = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == 1 && chk_drop) chk("C_done_drop", {31'd0, DONE_C}, 0);
      if (k == abort_at) begin
        #2;
        RESET_N = 1'b0;
        #1;
        chk("C_abort_pat", {29'd0, PAT_C}, 0);
        chk("C_abort_busy", {31'd0, BUSY_C}, 0);
        chk("C_abort_sig", {16'd0, SIG_C}, 0);
        chk("C_abort_done", {31'd0, DONE_C | PASS_C}, 0);
        pat_q.delete();
        res_q.delete();
        START_C = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        return;
      end
    end
    @(posedge CLOCK); #1;
    START_C = 1'b0;
    @(posedge CLOCK); #1;
    chk("C_done_seen", res_q.size(), 0);
    chk("C_done_sticky", {31'd0, DONE_C}, 1);
    pat_q.delete();
    res_q.delete();
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [2:0] exp_a[1:7];
    logic [7:0] l;
    RESET_N = 1'b1;
    START_A = 1'b0;
    START_B = 1'b0;
    START_C = 1'b0;
    RESP_C  = 6'd0;
    #1 RESET_N = 1'b0;
    #2;
    chk("rst_pat", {29'd0, PAT_A | PAT_C}, 0);
    chk("rst_flags", {28'd0, BUSY_A, DONE_A, PASS_A, DONE_C}, 0);
    chk("rst_sig", {16'd0, SIG_A | SIG_C}, 0);
    repeat (2) @(posedge CLOCK);
    #1 RESET_N = 1'b1;

    // Instance A expectation: 2 clear cycles, 4 LFSR patterns, flush
    exp_a[1] = 3'b001;
    exp_a[2] = 3'b001;
    l = 8'h01;
    for (int j = 3; j <= 6; j++) begin
      exp_a[j] = l[2:0];
      l = m_lfsr(l);
    end
    exp_a[7] = 3'b000;

    @(posedge CLOCK); #1;
    START_A = 1'b1;
    START_B = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLOCK); #1;
      START_A = 1'b0;
      START_B = 1'b0;
      if (k <= 7) chk("A_pat", {29'd0, PAT_A}, {29'd0, exp_a[k]});
      chk("A_done", {31'd0, DONE_A}, {31'd0, (k >= 8)});
      chk("B_done", {31'd0, DONE_B}, {31'd0, (k >= 7)});
      if (k == 8) begin
        chk("A_sig", {16'd0, SIG_A}, 0);
        chk("A_pass", {31'd0, PASS_A}, 1);
        chk("B_sig", {16'd0, SIG_B}, 32'h0001);
        chk("B_pass", {31'd0, PASS_B}, 1);
      end
    end

    run_c(1'b0, 0, 6'd0, 1'b0, 0);                         // plain run
    run_c(1'b1, 0, 6'd0, 1'b1, 0);                         // START spam, restart from FINISH
    run_c(1'b0, int'($urandom_range(1, NC)),
          6'(1 << $urandom_range(0, 5)), 1'b1, 0);         // single-bit response error
    run_c(1'b0, 0, 6'd0, 1'b1, 0);                         // clean rerun
    run_c(1'b0, 0, 6'd0, 1'b1, int'($urandom_range(10, 250))); // reset mid-run
    run_c(1'b0, 0, 6'd0, 1'b0, 0);                         // fresh run after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
